stm32_bus_master: RTL and testbench

// Initiator side of the 8-bit DATA_BUS/DATA_SYNC command link whose FPGA responder decodes commands 1-6 and 8-10.

---
 rtl/stm32_bus_pkg.sv | 37 +++
 rtl/stm32_bus_fifo.sv | 60 ++++++
 rtl/stm32_bus_master.sv | 208 ++++++++++++++++++++
 tb/tb_stm32_bus_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stm32_bus_pkg.sv
// Shared definitions for the STM32 command-link initiator: command codes, decode helpers
// and the FSM state type.
package stm32_bus_pkg;

  localparam logic [7:0] CMD_BUS_TEST     = 8'd0;
  localparam logic [7:0] CMD_SET_PARAMS   = 8'd1;
  localparam logic [7:0] CMD_GET_STATUS   = 8'd2;
  localparam logic [7:0] CMD_SET_FREQ     = 8'd3;
  localparam logic [7:0] CMD_RX_IQ        = 8'd4;
  localparam logic [7:0] CMD_TX_ON        = 8'd5;
  localparam logic [7:0] CMD_TX_OFF       = 8'd6;
  localparam logic [7:0] CMD_RESERVED     = 8'd7;
  localparam logic [7:0] CMD_GET_PARAMS   = 8'd8;
  localparam logic [7:0] CMD_RESET_TX_ON  = 8'd9;
  localparam logic [7:0] CMD_RESET_TX_OFF = 8'd10;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSync,
    StWrite,
    StRgap,
    StRead,
    StGap
  } state_e;

  // Commands whose payload flows from responder to master.
  function automatic logic is_read(input logic [7:0] code);
    return (code == CMD_GET_STATUS) || (code == CMD_RX_IQ) || (code == CMD_GET_PARAMS);
  endfunction

  // Codes the responder decodes; 0, 7 and anything above 10 are rejected.
  function automatic logic is_legal(input logic [7:0] code);
    return (code >= CMD_SET_PARAMS) && (code <= CMD_RESET_TX_OFF) && (code != CMD_RESERVED);
  endfunction

endpackage

// File: rtl/stm32_bus_fifo.sv
// Synchronous byte FIFO holding write payload ahead of a frame. Combinational head read,
// simultaneous push/pop supported, pushes when full and pops when empty are ignored.
module stm32_bus_fifo #(
  parameter int unsigned Depth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [7:0]                 rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wptr_d  = do_push ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AddrW'(1) : rptr_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/stm32_bus_master.sv
// Initiator end of the 8-bit DATA_BUS/DATA_SYNC command link. One command per request:
// a DATA_SYNC cycle carrying the code, then a fixed-length write or read payload.
module stm32_bus_master
  import stm32_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic [5:0] cmd_len,
  output logic       cmd_err,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       busy,
  output logic       DATA_SYNC,
  output logic [7:0] DATA_BUS_OUT,
  output logic       DATA_BUS_OE,
  input  logic [7:0] DATA_BUS_IN
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [5:0] len_q, len_d;
  logic [5:0] cnt_q, cnt_d;
  logic       sync_q, sync_d;
  logic       oe_q, oe_d;
  logic [7:0] bus_q, bus_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       run_q;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            cmd_is_read, cmd_too_long, cmd_have_bytes, fill_done;

  // run_q keeps wr_ready low while reset is held, like every other output.
  assign wr_ready  = run_q && !fifo_full;
  assign fifo_push = wr_valid && wr_ready;

  assign cmd_is_read    = is_read(cmd_code);
  assign cmd_too_long   = 32'(cmd_len) > FIFO_DEPTH;
  assign cmd_have_bytes = 32'(fifo_count) >= 32'(cmd_len);
  assign fill_done      = 32'(fifo_count) >= 32'(len_q);

  assign cmd_ready    = ready_q;
  assign cmd_err      = err_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign busy         = (state_q != StIdle);
  assign DATA_SYNC    = sync_q;
  assign DATA_BUS_OUT = bus_q;
  assign DATA_BUS_OE  = oe_q;

  stm32_bus_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (reset_in),
    .push_i  (fifo_push),
    .wdata_i (wr_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state and next bus/strobe values; outputs are registered so each state's bus
  // value is set up on the edge that enters it.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sync_d     = 1'b0;
    oe_d       = 1'b0;
    bus_d      = 8'h00;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;
    fifo_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && ready_q) begin
          if (!is_legal(cmd_code) || (!cmd_is_read && cmd_too_long)) begin
            err_d = 1'b1;
          end else begin
            code_d = cmd_code;
            len_d  = cmd_len;
            if (cmd_is_read || cmd_have_bytes) begin
              state_d = StSync;
              sync_d  = 1'b1;
              oe_d    = 1'b1;
              bus_d   = cmd_code;
            end else begin
              state_d = StFill;
            end
          end
        end
      end
      StFill: begin
        if (fill_done) begin
          state_d = StSync;
          sync_d  = 1'b1;
          oe_d    = 1'b1;
          bus_d   = code_q;
        end
      end
      StSync: begin
        cnt_d = '0;
        if (len_q == '0) begin
          state_d = StGap;
        end else if (is_read(code_q)) begin
          state_d = StRgap;
        end else begin
          // First payload byte goes out on E0, straight after the sync cycle.
          state_d  = StWrite;
          fifo_pop = 1'b1;
          oe_d     = 1'b1;
          bus_d    = fifo_rdata;
          cnt_d    = 6'd1;
        end
      end
      StWrite: begin
        if ((cnt_q < len_q) && !fifo_empty) begin
          fifo_pop = 1'b1;
          oe_d     = 1'b1;
          bus_d    = fifo_rdata;
          cnt_d    = cnt_q + 6'd1;
        end else begin
          state_d = StGap;
        end
      end
      StRgap: begin
        // Bus turnaround: responder starts driving during this cycle.
        state_d = StRead;
        cnt_d   = '0;
      end
      StRead: begin
        rd_valid_d = 1'b1;
        rd_data_d  = DATA_BUS_IN;
        cnt_d      = cnt_q + 6'd1;
        if (cnt_q == len_q - 6'd1) begin
          rd_last_d = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
  end

  // State, payload counter and registered output flops; reset aborts any frame at once.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      code_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      sync_q     <= 1'b0;
      oe_q       <= 1'b0;
      bus_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sync_q     <= sync_d;
      oe_q       <= oe_d;
      bus_q      <= bus_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stm32_bus_master.sv
// Directed bench for stm32_bus_master: write, read, fill-stall, zero-length, reject and
// mid-frame reset scenarios with a simple responder model driving DATA_BUS_IN.
module tb_stm32_bus_master;

  logic       clk_in;
  logic       reset_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_code;
  logic [5:0] cmd_len;
  logic       cmd_err;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       busy;
  logic       DATA_SYNC;
  logic [7:0] DATA_BUS_OUT;
  logic       DATA_BUS_OE;
  logic [7:0] DATA_BUS_IN;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder model: after the DATA_SYNC edge (E0) it drives byte k between E(k+1) and E(k+2).
  logic [7:0] resp [16];
  logic [6:0] slv_cnt = 7'd127;
  logic [6:0] slv_idx;

  assign slv_idx     = slv_cnt - 7'd1;
  assign DATA_BUS_IN = (slv_cnt >= 7'd1 && slv_cnt <= 7'd16) ? resp[slv_idx[3:0]] : 8'hEE;

  always @(posedge clk_in) begin
    if (DATA_SYNC) slv_cnt <= 7'd0;
    else if (slv_cnt != 7'd127) slv_cnt <= slv_cnt + 7'd1;
  end

  stm32_bus_master #(
    .FIFO_DEPTH (32)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_len      (cmd_len),
    .cmd_err      (cmd_err),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .busy         (busy),
    .DATA_SYNC    (DATA_SYNC),
    .DATA_BUS_OUT (DATA_BUS_OUT),
    .DATA_BUS_OE  (DATA_BUS_OE),
    .DATA_BUS_IN  (DATA_BUS_IN)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk_in);
    wr_valid = 1'b0;
  endtask

  // Present a command for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [7:0] code, input logic [5:0] len);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_len   = len;
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] zcodes [4];
    zcodes[0] = 8'd5; zcodes[1] = 8'd6; zcodes[2] = 8'd9; zcodes[3] = 8'd10;
    reset_in  = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync", DATA_SYNC, 0);
    chk("rst_oe", DATA_BUS_OE, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_cmd_err", cmd_err, 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_wr_ready", wr_ready, 1);

    // Write cmd 1, len 22, payload preloaded
    for (int i = 1; i <= 22; i++) push(8'(i));
    issue(8'd1, 6'd22);
    chk("w22_sync", DATA_SYNC, 1);
    chk("w22_sync_bus", DATA_BUS_OUT, 8'h01);
    chk("w22_sync_oe", DATA_BUS_OE, 1);
    chk("w22_busy", busy, 1);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_in);
      chk("w22_byte", DATA_BUS_OUT, 32'(i + 1));
      chk("w22_oe", DATA_BUS_OE, 1);
      chk("w22_nosync", DATA_SYNC, 0);
    end
    @(negedge clk_in);
    chk("w22_gap_oe", DATA_BUS_OE, 0);
    chk("w22_gap_busy", busy, 1);
    chk("w22_gap_ready", cmd_ready, 0);
    @(negedge clk_in);
    chk("w22_idle_ready", cmd_ready, 1);
    chk("w22_idle_busy", busy, 0);

    // Read cmd 8, len 3
    resp[0] = 8'h04; resp[1] = 8'h01; resp[2] = 8'h00;
    issue(8'd8, 6'd3);
    chk("r3_sync", DATA_SYNC, 1);
    chk("r3_sync_bus", DATA_BUS_OUT, 8'h08);
    @(negedge clk_in);
    chk("r3_rgap_oe", DATA_BUS_OE, 0);
    chk("r3_rgap_rv", rd_valid, 0);
    @(negedge clk_in);
    chk("r3_e1_rv", rd_valid, 0);
    @(negedge clk_in);
    chk("r3_b0_rv", rd_valid, 1);
    chk("r3_b0", rd_data, 8'h04);
    chk("r3_b0_last", rd_last, 0);
    @(negedge clk_in);
    chk("r3_b1", rd_data, 8'h01);
    chk("r3_b1_last", rd_last, 0);
    @(negedge clk_in);
    chk("r3_b2_rv", rd_valid, 1);
    chk("r3_b2", rd_data, 8'h00);
    chk("r3_b2_last", rd_last, 1);
    chk("r3_b2_oe", DATA_BUS_OE, 0);
    @(negedge clk_in);
    chk("r3_done_rv", rd_valid, 0);
    chk("r3_done_ready", cmd_ready, 1);

    // Write cmd 3, len 6, buffer short by two bytes
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    issue(8'd3, 6'd6);
    chk("fill_busy", busy, 1);
    chk("fill_nosync0", DATA_SYNC, 0);
    @(negedge clk_in);
    chk("fill_nosync1", DATA_SYNC, 0);
    push(8'hA4);
    push(8'hA5);
    chk("fill_nosync2", DATA_SYNC, 0);
    @(negedge clk_in);
    chk("fill_sync", DATA_SYNC, 1);
    chk("fill_sync_bus", DATA_BUS_OUT, 8'h03);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("fill_byte", DATA_BUS_OUT, 32'(8'hA0 + i));
      chk("fill_oe", DATA_BUS_OE, 1);
    end
    @(negedge clk_in);
    chk("fill_gap_oe", DATA_BUS_OE, 0);
    @(negedge clk_in);
    chk("fill_ready", cmd_ready, 1);

    // Zero-length commands
    for (int k = 0; k < 4; k++) begin
      issue(zcodes[k], 6'd0);
      chk("z_sync", DATA_SYNC, 1);
      chk("z_bus", DATA_BUS_OUT, 32'(zcodes[k]));
      chk("z_oe", DATA_BUS_OE, 1);
      @(negedge clk_in);
      chk("z_gap_sync", DATA_SYNC, 0);
      chk("z_gap_oe", DATA_BUS_OE, 0);
      chk("z_gap_busy", busy, 1);
      @(negedge clk_in);
      chk("z_ready", cmd_ready, 1);
      chk("z_idle_busy", busy, 0);
    end

    // Rejected commands
    issue(8'd7, 6'd2);
    chk("rej7_err", cmd_err, 1);
    chk("rej7_nosync", DATA_SYNC, 0);
    chk("rej7_busy", busy, 0);
    @(negedge clk_in);
    chk("rej7_err_clr", cmd_err, 0);
    chk("rej7_ready", cmd_ready, 1);
    issue(8'd0, 6'd0);
    chk("rej0_err", cmd_err, 1);
    issue(8'd11, 6'd0);
    chk("rej11_err", cmd_err, 1);
    chk("rej11_nosync", DATA_SYNC, 0);
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
    issue(8'd1, 6'd40);
    chk("rej40_err", cmd_err, 1);
    chk("rej40_nosync", DATA_SYNC, 0);
    @(negedge clk_in);
    // Three bytes still buffered, so a len-3 write starts without filling.
    issue(8'd1, 6'd3);
    chk("keep_sync", DATA_SYNC, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("keep_byte", DATA_BUS_OUT, 32'(8'hB0 + i));
    end
    repeat (2) @(negedge clk_in);
    chk("keep_ready", cmd_ready, 1);

    // Reset in the middle of an RX IQ read
    push(8'hD0);
    push(8'hD1);
    for (int i = 0; i < 6; i++) resp[i] = 8'h11 + 8'(i);
    issue(8'd4, 6'd6);
    chk("iq_sync_bus", DATA_BUS_OUT, 8'h04);
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("iq_rv", rd_valid, 1);
      chk("iq_byte", rd_data, 32'(8'h11 + i));
    end
    reset_in = 1'b1;
    #1;
    chk("mrst_sync", DATA_SYNC, 0);
    chk("mrst_oe", DATA_BUS_OE, 0);
    chk("mrst_rv", rd_valid, 0);
    chk("mrst_busy", busy, 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    chk("mrst_ready", cmd_ready, 1);
    // Buffer was emptied: a len-1 write must wait in fill.
    issue(8'd1, 6'd1);
    chk("mrst_fill_busy", busy, 1);
    chk("mrst_fill_nosync", DATA_SYNC, 0);
    push(8'hE0);
    chk("mrst_fill_nosync2", DATA_SYNC, 0);
    @(negedge clk_in);
    chk("mrst_fill_sync", DATA_SYNC, 1);
    @(negedge clk_in);
    chk("mrst_fill_byte", DATA_BUS_OUT, 8'hE0);
    repeat (2) @(negedge clk_in);
    chk("mrst_fill_ready", cmd_ready, 1);

    // Fresh RX IQ, len 6
    for (int i = 0; i < 6; i++) resp[i] = 8'h21 + 8'(i);
    issue(8'd4, 6'd6);
    chk("iq2_sync", DATA_SYNC, 1);
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("iq2_rv", rd_valid, 1);
      chk("iq2_byte", rd_data, 32'(8'h21 + i));
      chk("iq2_last", rd_last, (i == 5) ? 1 : 0);
    end
    @(negedge clk_in);
    chk("iq2_done_rv", rd_valid, 0);
    chk("iq2_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
